// File: rtl/ldpc_3gpp_dec_mem_pp.sv
// ldpc_3gpp_dec_mem_pp: ping-pong node memory, linear loader fill plus circulant-shifted decoder access
module ldpc_3gpp_dec_mem_pp #(
  parameter int pADDR_W       = 8,
  parameter int pNODE_W       = 8,
  parameter int pLLR_BY_CYCLE = 1,
  parameter int pCHAN_N       = 8,
  parameter int pRD_LAT       = 2,
  parameter int pBANK_N       = 2
) (
  input  logic                                                  iclk,
  input  logic                                                  ireset,
  input  logic                                                  iclkena,
  input  logic [pADDR_W:0]                                      iused_zc,
  input  logic                                                  ild_write,
  input  logic                                                  ild_start,
  input  logic [pCHAN_N-1:0][pLLR_BY_CYCLE-1:0][pNODE_W-1:0]    ild_dat,
  input  logic                                                  iwrite,
  input  logic                                                  iwstart,
  input  logic [pCHAN_N-1:0][pADDR_W-1:0]                       iwshift,
  input  logic [pCHAN_N-1:0]                                    iwmask,
  input  logic [pCHAN_N-1:0][pLLR_BY_CYCLE-1:0][pNODE_W-1:0]    iwdat,
  input  logic                                                  iread,
  input  logic                                                  irstart,
  input  logic [pCHAN_N-1:0][pADDR_W-1:0]                       irshift,
  input  logic [pCHAN_N-1:0]                                    irmask,
  input  logic                                                  irval,
  input  logic [3:0]                                            irstrb,
  input  logic                                                  iswap,
  output logic                                                  orval,
  output logic [3:0]                                            orstrb,
  output logic [pCHAN_N-1:0]                                    ormask,
  output logic [pCHAN_N-1:0][pLLR_BY_CYCLE-1:0][pNODE_W-1:0]    ordat,
  output logic                                                  oswap_ack,
  output logic [1:0]                                            oact_bank,
  output logic                                                  oswap_pend
);
  localparam int WW = pLLR_BY_CYCLE * pNODE_W;
  localparam int BW = $clog2(pBANK_N);
  typedef logic [pADDR_W-1:0] addr_t;
  typedef logic [pCHAN_N-1:0][WW-1:0] dat_t;

  logic [WW-1:0] mem [pBANK_N][pCHAN_N][2**pADDR_W];
  logic [1:0] act_bank, ld_bank;
  addr_t lcnt, wcnt, rcnt, lcnt_e, wcnt_e, rcnt_e;
  logic swap_pend, swap_go;
  logic [pCHAN_N-1:0][pADDR_W-1:0] waddr, raddr;
  dat_t rd_dat;
  logic [pRD_LAT-1:0] p_val, p_busy;
  logic [3:0] p_strb [pRD_LAT];
  logic [pCHAN_N-1:0] p_mask [pRD_LAT];
  dat_t p_dat [pRD_LAT];

  function automatic addr_t cnt_next(addr_t cnt, logic stb, logic [pADDR_W:0] used);
    return stb ? (({1'b0, cnt} == used - 1'b1) ? '0 : cnt + 1'b1) : cnt;
  endfunction

  // modular add without a divider: shift and count are both below used
  function automatic addr_t shift_addr(addr_t sh, addr_t cnt, logic [pADDR_W:0] used);
    logic [pADDR_W:0] sum;
    logic [pADDR_W:0] wrap;
    sum  = {1'b0, sh} + {1'b0, cnt};
    wrap = (sum >= used) ? sum - used : sum;
    return wrap[pADDR_W-1:0];
  endfunction

  assign lcnt_e  = ild_start ? '0 : lcnt;
  assign wcnt_e  = iwstart ? '0 : wcnt;
  assign rcnt_e  = irstart ? '0 : rcnt;
  assign ld_bank = (act_bank == 2'(pBANK_N - 1)) ? 2'd0 : act_bank + 2'd1;
  assign swap_go = iclkena & swap_pend & ~iread & ~|p_busy;

  always_comb begin
    waddr  = '0;
    raddr  = '0;
    rd_dat = '0;
    for (int c = 0; c < pCHAN_N; c++) begin
      waddr[c]  = shift_addr(iwshift[c], wcnt_e, iused_zc);
      raddr[c]  = shift_addr(irshift[c], rcnt_e, iused_zc);
      rd_dat[c] = irmask[c] ? '0 :
                  (iwrite && !iwmask[c] && waddr[c] == raddr[c]) ? iwdat[c] :
                  mem[act_bank[BW-1:0]][c][raddr[c]];
    end
  end

  always_ff @(posedge iclk) begin
    if (iclkena) begin
      for (int c = 0; c < pCHAN_N; c++) begin
        if (ild_write) mem[ld_bank[BW-1:0]][c][lcnt_e] <= ild_dat[c];
        if (iwrite && !iwmask[c]) mem[act_bank[BW-1:0]][c][waddr[c]] <= iwdat[c];
      end
    end
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      act_bank  <= '0;
      swap_pend <= 1'b0;
      lcnt      <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
      p_val     <= '0;
      p_busy    <= '0;
      for (int i = 0; i < pRD_LAT; i++) begin
        p_strb[i] <= '0;
        p_mask[i] <= '0;
        p_dat[i]  <= '0;
      end
    end else if (iclkena) begin
      swap_pend <= iswap | (swap_pend & ~swap_go);
      act_bank  <= swap_go ? ld_bank : act_bank;
      lcnt      <= swap_go ? '0 : cnt_next(lcnt_e, ild_write, iused_zc);
      wcnt      <= swap_go ? '0 : cnt_next(wcnt_e, iwrite, iused_zc);
      rcnt      <= swap_go ? '0 : cnt_next(rcnt_e, iread, iused_zc);
      for (int i = pRD_LAT - 1; i > 0; i--) begin
        p_val[i]  <= p_val[i-1];
        p_busy[i] <= p_busy[i-1];
        p_strb[i] <= p_strb[i-1];
        p_mask[i] <= p_mask[i-1];
        p_dat[i]  <= p_dat[i-1];
      end
      p_val[0]  <= irval & iread;
      p_busy[0] <= iread;
      p_strb[0] <= irstrb;
      p_mask[0] <= irmask;
      p_dat[0]  <= rd_dat;
    end
  end

  assign orval      = p_val[pRD_LAT-1];
  assign orstrb     = p_strb[pRD_LAT-1];
  assign ormask     = p_mask[pRD_LAT-1];
  assign ordat      = p_dat[pRD_LAT-1];
  assign oswap_ack  = swap_go;
  assign oact_bank  = act_bank;
  assign oswap_pend = swap_pend;
endmodule

// File: tb/tb_ldpc_3gpp_dec_mem_pp.sv
// tb_ldpc_3gpp_dec_mem_pp: directed bench for the ping-pong node memory (3 banks, 4 channels)
module tb_ldpc_3gpp_dec_mem_pp;
  localparam int AW = 8, NW = 8, CN = 4, LAT = 2, BN = 3;
  logic iclk = 1'b0, ireset = 1'b0, iclkena = 1'b1;
  logic [AW:0] iused_zc = 9'd5;
  logic ild_write, ild_start, iwrite, iwstart, iread, irstart, irval, iswap;
  logic [CN-1:0][0:0][NW-1:0] ild_dat, iwdat, ordat;
  logic [CN-1:0][AW-1:0] iwshift, irshift;
  logic [CN-1:0] iwmask, irmask, ormask;
  logic [3:0] irstrb, orstrb;
  logic orval, oswap_ack, oswap_pend;
  logic [1:0] oact_bank;
  int n_cmp = 0, n_err = 0;
  int seq1 [5] = '{3, 4, 0, 1, 2};

  ldpc_3gpp_dec_mem_pp #(.pADDR_W(AW), .pNODE_W(NW), .pLLR_BY_CYCLE(1), .pCHAN_N(CN),
                         .pRD_LAT(LAT), .pBANK_N(BN)) dut (
    .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .iused_zc(iused_zc),
    .ild_write(ild_write), .ild_start(ild_start), .ild_dat(ild_dat),
    .iwrite(iwrite), .iwstart(iwstart), .iwshift(iwshift), .iwmask(iwmask), .iwdat(iwdat),
    .iread(iread), .irstart(irstart), .irshift(irshift), .irmask(irmask),
    .irval(irval), .irstrb(irstrb), .iswap(iswap),
    .orval(orval), .orstrb(orstrb), .ormask(ormask), .ordat(ordat),
    .oswap_ack(oswap_ack), .oact_bank(oact_bank), .oswap_pend(oswap_pend)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge iclk);
    #1;
  endtask

  task automatic clr;
    ild_write = 0; ild_start = 0; iwrite = 0; iwstart = 0;
    iread = 0; irstart = 0; irval = 0; iswap = 0;
  endtask

  initial begin
    clr;
    ild_dat = '0; iwdat = '0; iwshift = '0; irshift = '0;
    iwmask = '0; irmask = '0; irstrb = '0;
    #1 ireset = 1'b1;
    #2;
    chk("rst_orval", orval, 0);
    chk("rst_orstrb", orstrb, 0);
    chk("rst_ormask", ormask, 0);
    chk("rst_ordat", ordat, 0);
    chk("rst_ack", oswap_ack, 0);
    chk("rst_pend", oswap_pend, 0);
    chk("rst_bank", oact_bank, 0);
    tick;
    ireset = 1'b0;
    tick;
    // load bank 1 with address pattern, then swap it in
    for (int k = 0; k < 5; k++) begin
      ild_write = 1; ild_start = (k == 0);
      for (int c = 0; c < CN; c++) ild_dat[c][0] = 8'(c * 16 + k);
      tick;
    end
    clr;
    iswap = 1;
    tick;
    iswap = 0;
    chk("sw1_pend", oswap_pend, 1);
    chk("sw1_ack", oswap_ack, 1);
    tick;
    chk("sw1_bank", oact_bank, 1);
    chk("sw1_ack_low", oswap_ack, 0);
    chk("sw1_pend_low", oswap_pend, 0);
    for (int c = 0; c < CN; c++) irshift[c] = 8'd3;
    irval = 1;
    for (int k = 0; k < 6; k++) begin
      iread = (k < 5); irstart = (k == 0); irstrb = 4'(k + 1);
      tick;
      if (k > 0) begin
        chk("rd1_val", orval, 1);
        chk("rd1_ch0", ordat[0], 64'(seq1[k-1]));
        chk("rd1_ch3", ordat[3], 64'(48 + seq1[k-1]));
        chk("rd1_strb", orstrb, 64'(k));
      end
    end
    clr;
    tick;
    chk("rd1_val_end", orval, 0);
    // decoder write with shift 2, read back with shift 2, channel 1 masked
    for (int c = 0; c < CN; c++) iwshift[c] = 8'd2;
    for (int k = 0; k < 5; k++) begin
      iwrite = 1; iwstart = (k == 0);
      for (int c = 0; c < CN; c++) iwdat[c][0] = 8'(8'hA0 + c * 8 + k);
      tick;
    end
    clr;
    for (int c = 0; c < CN; c++) irshift[c] = 8'd2;
    irmask = 4'b0010; irval = 1;
    for (int k = 0; k < 6; k++) begin
      iread = (k < 5); irstart = (k == 0); irstrb = 4'(k + 8);
      tick;
      if (k > 0) begin
        chk("rd2_ch0", ordat[0], 64'(8'hA0 + k - 1));
        chk("rd2_ch1_masked", ordat[1], 0);
        chk("rd2_ch2", ordat[2], 64'(8'hB0 + k - 1));
        chk("rd2_mask", ormask, 4'b0010);
        chk("rd2_strb", orstrb, 64'(k + 7));
      end
    end
    clr;
    irmask = '0;
    // same-cycle write/read at address 4: channel 0 bypassed, channel 1 write masked
    for (int c = 0; c < CN; c++) begin iwshift[c] = 8'd4; irshift[c] = 8'd4; end
    iwmask = 4'b1110;
    iwdat[0][0] = 8'h5A; iwdat[1][0] = 8'hEE;
    iwrite = 1; iwstart = 1; iread = 1; irstart = 1; irval = 1;
    tick;
    iwrite = 0; iwstart = 0;
    tick;
    chk("byp_ch0", ordat[0], 8'h5A);
    chk("byp_ch1", ordat[1], 8'hAA);
    clr;
    tick;
    chk("ram_ch0", ordat[0], 8'h5A);
    chk("ram_ch1", ordat[1], 8'hAA);
    iwmask = '0;
    // swap requested during a 3-read burst
    irshift = '0;
    iread = 1; irstart = 1; irval = 1; iswap = 1;
    tick;
    iswap = 0; irstart = 0;
    tick;
    chk("sw2_pend_a", oswap_pend, 1);
    chk("sw2_rd0", ordat[0], 8'hA3);
    tick;
    chk("sw2_pend_b", oswap_pend, 1);
    chk("sw2_rd1", ordat[0], 8'hA4);
    clr;
    tick;
    chk("sw2_val_last", orval, 1);
    chk("sw2_rd2_old", ordat[0], 8'hA0);
    chk("sw2_pend_c", oswap_pend, 1);
    chk("sw2_ack_early", oswap_ack, 0);
    tick;
    chk("sw2_val_gone", orval, 0);
    chk("sw2_ack", oswap_ack, 1);
    chk("sw2_bank_old", oact_bank, 1);
    tick;
    chk("sw2_bank", oact_bank, 2);
    chk("sw2_ack_low", oswap_ack, 0);
    chk("sw2_pend_low", oswap_pend, 0);
    // active 2: load bank 0, write bank 2, bank 1 parked
    for (int k = 0; k < 5; k++) begin
      ild_write = 1; ild_start = (k == 0); iwrite = 1; iwstart = (k == 0);
      for (int c = 0; c < CN; c++) begin ild_dat[c][0] = 8'h77; iwdat[c][0] = 8'h66; end
      tick;
    end
    clr;
    iswap = 1;
    tick;
    iswap = 0;
    tick;
    chk("sw3_bank", oact_bank, 0);
    iread = 1; irstart = 1; irval = 1;
    tick;
    clr;
    tick;
    chk("b0_load", ordat[0], 8'h77);
    iswap = 1;
    tick;
    iswap = 0;
    tick;
    chk("sw4_bank", oact_bank, 1);
    iread = 1; irstart = 1; irval = 1;
    tick;
    clr;
    tick;
    chk("park_ch0", ordat[0], 8'hA3);
    chk("park_ch2", ordat[2], 8'hB3);
    // reset with reads in flight
    iread = 1; irval = 1;
    tick;
    tick;
    chk("pre_rst_val", orval, 1);
    #2 ireset = 1'b1;
    #1;
    chk("rst2_val", orval, 0);
    chk("rst2_bank", oact_bank, 0);
    chk("rst2_dat", ordat, 0);
    clr;
    tick;
    ireset = 1'b0;
    tick;
    chk("rst2_val_a", orval, 0);
    tick;
    chk("rst2_val_b", orval, 0);
    // clock-enable stall of 4 cycles
    iread = 1; irval = 1; irstrb = 4'hC;
    tick;
    clr;
    iclkena = 0;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk("stall_val", orval, 0);
    end
    iclkena = 1;
    tick;
    chk("stall_out_val", orval, 1);
    chk("stall_out_dat", ordat[0], 8'h77);
    chk("stall_out_strb", orstrb, 4'hC);
    tick;
    chk("stall_after", orval, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
